mcdt_pkt_fmt: RTL

MCDT_PKT_FMT -- requirements
Module: mcdt_pkt_fmt

---
 rtl/mcdt_fmt_pkg.sv | 42 ++++
 rtl/mcdt_fmt_fifo.sv | 54 +++++
 rtl/mcdt_pkt_fmt.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mcdt_fmt_pkg.sv
// Shared definitions for the multi-channel packet formatter: FSM states,
// channel count and small decode/arbitration helpers.
package mcdt_fmt_pkg;

  localparam int CH_NUM = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } fmt_state_e;

  function automatic logic [5:0] len_decode(input logic [1:0] sel);
    case (sel)
      2'd0:    return 6'd4;
      2'd1:    return 6'd8;
      2'd2:    return 6'd16;
      2'd3:    return 6'd32;
      default: return 6'd4;
    endcase
  endfunction

  // Returns {found, channel}: first eligible channel after 'last' in round-robin order.
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [1:0] o0, o1, o2;
    case (last)
      2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (elig[o0]) begin
      return {1'b1, o0};
    end else if (elig[o1]) begin
      return {1'b1, o1};
    end else if (elig[o2]) begin
      return {1'b1, o2};
    end else begin
      return 3'b000;
    end
  endfunction

endpackage

// File: rtl/mcdt_fmt_fifo.sv
// Per-channel synchronous FIFO with occupancy count. A write while full is
// accepted only when a read of this FIFO happens in the same cycle.
module mcdt_fmt_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s, pop_s;

  assign empty   = (count_r == {(AW+1){1'b0}});
  assign full    = (count_r == (AW+1)'(DEPTH));
  assign count   = count_r;
  assign pop_s   = rd_en && !empty;
  assign push_s  = wr_en && (!full || pop_s);
  assign rd_data = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/mcdt_pkt_fmt.sv
// Multi-channel packet formatter: buffers arbiter words per channel and emits
// fixed-length packets with a req/grant handshake. Define FMT_PARITY_EN to add fmt_parity_o.
module mcdt_pkt_fmt
  import mcdt_fmt_pkg::*;
#(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] mcdt_data_i,
  input  logic          mcdt_val_i,
  input  logic [1:0]    mcdt_id_i,
  input  logic [1:0]    fmt_len_sel_i,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_length_o,
  output logic          fmt_valid_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic [DW-1:0] fmt_data_o,
  output logic [2:0]    fmt_overflow_o
`ifdef FMT_PARITY_EN
  ,
  output logic          fmt_parity_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fmt_state_e          state_r, state_nx_s;
  logic [1:0]          chid_r, chid_nx_s, last_r, last_nx_s;
  logic [5:0]          len_r, len_nx_s, idx_r, idx_nx_s, len_now_s;
  logic                req_r, req_nx_s, valid_r, valid_nx_s;
  logic                start_r, start_nx_s, end_r, end_nx_s;
  logic [DW-1:0]       data_r, data_nx_s;
  logic [CH_NUM-1:0]   ovf_r, wr_s, rd_s, full_s, empty_s, elig_s;
  logic [CW-1:0]       cnt_s   [CH_NUM];
  logic [DW-1:0]       rdata_s [CH_NUM];
  logic                pop_s;
  logic [2:0]          pick_s;

  assign len_now_s = len_decode(fmt_len_sel_i);
  assign pick_s    = rr_pick(elig_s, last_r);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign wr_s[g]   = mcdt_val_i && (mcdt_id_i == 2'(g));
    assign rd_s[g]   = pop_s && (chid_r == 2'(g)) && !empty_s[g];
    assign elig_s[g] = (32'(cnt_s[g]) >= 32'(len_now_s));

    mcdt_fmt_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .wr_en   (wr_s[g]),
      .wr_data (mcdt_data_i),
      .rd_en   (rd_s[g]),
      .rd_data (rdata_s[g]),
      .count   (cnt_s[g]),
      .full    (full_s[g]),
      .empty   (empty_s[g])
    );
  end

  // Next-state and next-output decode; idx counts words already presented.
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = 1'b0;
    valid_nx_s = 1'b0;
    start_nx_s = 1'b0;
    end_nx_s   = 1'b0;
    data_nx_s  = {DW{1'b0}};
    chid_nx_s  = chid_r;
    len_nx_s   = len_r;
    last_nx_s  = last_r;
    idx_nx_s   = idx_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_nx_s = ST_REQ;
          req_nx_s   = 1'b1;
          chid_nx_s  = pick_s[1:0];
          len_nx_s   = len_now_s;
          last_nx_s  = pick_s[1:0];
          idx_nx_s   = 6'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (fmt_grant_i) begin
          state_nx_s = ST_SEND;
          pop_s      = 1'b1;
          valid_nx_s = 1'b1;
          start_nx_s = 1'b1;
          data_nx_s  = rdata_s[chid_r];
          idx_nx_s   = 6'd1;
        end else begin
          req_nx_s   = 1'b1;
        end
      end
      ST_SEND: begin
        if (idx_r == len_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          pop_s      = 1'b1;
          valid_nx_s = 1'b1;
          end_nx_s   = (idx_r == (len_r - 6'd1));
          data_nx_s  = rdata_s[chid_r];
          idx_nx_s   = idx_r + 6'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs and sticky overflow flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      last_r  <= 2'd2;
      chid_r  <= 2'd0;
      len_r   <= 6'd0;
      idx_r   <= 6'd0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
      start_r <= 1'b0;
      end_r   <= 1'b0;
      data_r  <= {DW{1'b0}};
      ovf_r   <= {CH_NUM{1'b0}};
    end else begin
      state_r <= state_nx_s;
      last_r  <= last_nx_s;
      chid_r  <= chid_nx_s;
      len_r   <= len_nx_s;
      idx_r   <= idx_nx_s;
      req_r   <= req_nx_s;
      valid_r <= valid_nx_s;
      start_r <= start_nx_s;
      end_r   <= end_nx_s;
      data_r  <= data_nx_s;
      ovf_r   <= ovf_r | (wr_s & full_s & ~rd_s);
    end
  end

  assign fmt_req_o      = req_r;
  assign fmt_chid_o     = chid_r;
  assign fmt_length_o   = len_r;
  assign fmt_valid_o    = valid_r;
  assign fmt_start_o    = start_r;
  assign fmt_end_o      = end_r;
  assign fmt_data_o     = data_r;
  assign fmt_overflow_o = ovf_r;

`ifdef FMT_PARITY_EN
  logic parity_r;

  function automatic logic even_parity(input logic [DW-1:0] d);
    return ^d;
  endfunction

  // Data is zero whenever no word is presented, so parity is zero there too.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= even_parity(data_nx_s);
    end
  end

  assign fmt_parity_o = parity_r;
`endif

endmodule
